// File: rtl/bram_dump_streamer.sv
// bram_dump_streamer: walks a word-aligned BRAM range through the debug read
// port and emits each 32-bit word as four little-endian bytes on a
// valid/ready byte stream (feeds the board UART TX for post-run inspection).
// Optional build macro DUMP_CHECKSUM_EN appends an 8-bit modulo-256 sum of all
// emitted bytes as one trailing byte; without it the block has no CSUM state.
module bram_dump_streamer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic [ADDR_WIDTH-1:0] debug_addr,
  input  logic [DATA_WIDTH-1:0] debug_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
`ifdef DUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_FINISH
  } state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [CNT_WIDTH-1:0]  remaining, remaining_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [1:0]            byte_idx, byte_idx_d;
  logic [7:0]            tx_data_d;
  logic                  tx_valid_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  hs;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]            csum, csum_d;
`endif

  // A byte is consumed on any edge where both sides agree.
  assign hs = tx_valid & tx_ready;

  // Next-state and next-datapath logic for the dump sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state;
    addr_d      = debug_addr;
    remaining_d = remaining;
    word_d      = word_q;
    byte_idx_d  = byte_idx;
    tx_data_d   = tx_data;
    tx_valid_d  = tx_valid;
    busy_d      = busy;
    done_d      = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    csum_d      = csum;
`endif

    case (state)
      S_IDLE: begin
        // done is still high in the first idle cycle; a start there is dropped.
        if (start && !done) begin
          addr_d      = base_addr & ~ADDR_WIDTH'(3);
          remaining_d = word_count;
          busy_d      = 1'b1;
`ifdef DUMP_CHECKSUM_EN
          csum_d      = 8'h00;
`endif
          if (word_count == '0) begin
`ifdef DUMP_CHECKSUM_EN
            // Empty range still reports its (zero) checksum.
            state_d    = S_CSUM;
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b1;
`else
            state_d    = S_FINISH;
`endif
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        // debug_addr settled last cycle, so debug_data is valid to capture.
        word_d     = debug_data;
        byte_idx_d = 2'd0;
        tx_data_d  = debug_data[7:0];
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end

      S_SEND: begin
        if (hs) begin
`ifdef DUMP_CHECKSUM_EN
          csum_d = csum + tx_data;
`endif
          if (byte_idx != 2'd3) begin
            byte_idx_d = byte_idx + 2'd1;
            word_d     = word_q >> 8;
            tx_data_d  = word_q[15:8];
          end else begin
            tx_valid_d  = 1'b0;
            remaining_d = remaining - CNT_WIDTH'(1);
            addr_d      = debug_addr + ADDR_WIDTH'(4);
            if (remaining == CNT_WIDTH'(1)) begin
`ifdef DUMP_CHECKSUM_EN
              state_d    = S_CSUM;
              tx_data_d  = csum + tx_data;
              tx_valid_d = 1'b1;
`else
              state_d    = S_FINISH;
`endif
            end else begin
              state_d = S_FETCH;
            end
          end
        end
      end

`ifdef DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (hs) begin
          tx_valid_d = 1'b0;
          state_d    = S_FINISH;
        end
      end
`endif

      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state      <= S_IDLE;
      debug_addr <= '0;
      remaining  <= '0;
      word_q     <= '0;
      byte_idx   <= 2'd0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      state      <= state_d;
      debug_addr <= addr_d;
      remaining  <= remaining_d;
      word_q     <= word_d;
      byte_idx   <= byte_idx_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      busy       <= busy_d;
      done       <= done_d;
`ifdef DUMP_CHECKSUM_EN
      csum       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_bram_dump_streamer.sv
// Scoreboard bench for bram_dump_streamer: stimulus pushes expected bytes
// into a queue, a negedge monitor pops and compares on every handshake.
// Honours DUMP_CHECKSUM_EN by appending the expected checksum byte.
module tb_bram_dump_streamer;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] word_count;
  logic [AW-1:0] debug_addr;
  logic [DW-1:0] debug_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;

  logic [31:0] mem [0:1023];
  assign debug_data = mem[debug_addr[AW-1:2]];

  bram_dump_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .debug_addr(debug_addr), .debug_data(debug_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] csum_model;
  int         hs_count = 0;
  int         first_hs_cyc = 0;
  int         last_hs_cyc = 0;
  int         cyc = 0;
  int         done_count = 0;
  int         stall_checks = 0;
  bit         ready_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b);
    csum_model = csum_model + b;
  endtask

  task automatic push_word(input logic [31:0] w);
    push_byte(w[7:0]);
    push_byte(w[15:8]);
    push_byte(w[23:16]);
    push_byte(w[31:24]);
  endtask

  task automatic begin_expect();
    csum_model = 8'h00;
    hs_count   = 0;
  endtask

  task automatic end_expect();
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(csum_model);
`endif
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
    @(posedge clk); #1;
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, {31'd0, found}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Downstream ready: held high, or toggled every cycle for backpressure.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode) tx_ready = ~tx_ready;
      else            tx_ready = 1'b1;
    end
  end

  // Monitor: compares accepted bytes, stall stability and done pulse width.
  initial begin
    bit         stall_pending = 1'b0;
    logic [7:0] stall_data = 8'h00;
    bit         prev_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (stall_pending) begin
          stall_checks++;
          check("stall_valid_held", {31'd0, tx_valid}, 32'd1);
          check("stall_data_held", {24'd0, tx_data}, {24'd0, stall_data});
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%02h expected=none", tx_data);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("stream_byte", {24'd0, tx_data}, {24'd0, e});
          end
          if (hs_count == 0) first_hs_cyc = cyc;
          last_hs_cyc = cyc;
          hs_count++;
        end
        stall_pending = tx_valid && !tx_ready;
        stall_data    = tx_data;
        if (done) begin
          done_count++;
          if (prev_done) begin
            checks++;
            errors++;
            $display("FAIL done_width actual=2+ cycles expected=1");
          end
        end
        prev_done = done;
      end else begin
        stall_pending = 1'b0;
        prev_done     = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int lat;
    rst        = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_0005;
    mem[1] = 32'h0000_0006;
    mem[2] = 32'h0000_0001;
    mem[4] = 32'hA1B2_C3D4;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_debug_addr", {20'd0, debug_addr}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rst = 1'b1;

    // Basic dump of three words with tx_ready held high
    begin_expect();
    push_word(32'h0000_0005);
    push_word(32'h0000_0006);
    push_word(32'h0000_0001);
    end_expect();
    dc = done_count;
    pulse_start(12'h000, 11'd3);
    check("basic_busy", {31'd0, busy}, 32'd1);
    check("basic_addr", {20'd0, debug_addr}, 32'h000);
    wait_done("basic");
    check("basic_busy_after", {31'd0, busy}, 32'd0);
    check("basic_done_once", done_count, dc + 1);
    check("basic_queue_empty", exp_q.size(), 32'd0);
`ifdef DUMP_CHECKSUM_EN
    check("basic_throughput", last_hs_cyc - first_hs_cyc, 32'd14);
`else
    check("basic_throughput", last_hs_cyc - first_hs_cyc, 32'd13);
`endif

    // Backpressure with unaligned base address
    begin_expect();
    push_word(32'hA1B2_C3D4);
    end_expect();
    ready_mode = 1'b1;
    pulse_start(12'h012, 11'd1);
    check("bp_aligned_addr", {20'd0, debug_addr}, 32'h010);
    wait_done("bp");
    ready_mode = 1'b0;
    check("bp_queue_empty", exp_q.size(), 32'd0);
    check("bp_stalls_seen", {31'd0, stall_checks > 0}, 32'd1);

    // Address wrap at the top of the BRAM
    mem[1023] = 32'h1111_1111;
    mem[0]    = 32'h2222_2222;
    begin_expect();
    push_word(32'h1111_1111);
    push_word(32'h2222_2222);
    end_expect();
    pulse_start(12'hFFC, 11'd2);
    check("wrap_first_addr", {20'd0, debug_addr}, 32'hFFC);
    wait_done("wrap");
    check("wrap_final_addr", {20'd0, debug_addr}, 32'h004);
    check("wrap_queue_empty", exp_q.size(), 32'd0);
    mem[0] = 32'h0000_0005;

    // Zero count, plus a start coinciding with the done pulse
    begin_expect();
    end_expect();
    dc  = done_count;
    lat = -1;
    pulse_start(12'h040, 11'd0);
    check("zero_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) begin
        lat        = i;
        base_addr  = 12'h000;
        word_count = 11'd1;
        start      = 1'b1;
        break;
      end
    end
`ifdef DUMP_CHECKSUM_EN
    check("zero_done_latency", lat, 32'd2);
`else
    check("zero_done_latency", lat, 32'd1);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    check("start_at_done_ignored", {31'd0, busy}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("zero_still_idle", {31'd0, busy}, 32'd0);
    check("zero_done_once", done_count, dc + 1);
`ifdef DUMP_CHECKSUM_EN
    check("zero_byte_count", hs_count, 32'd1);
`else
    check("zero_byte_count", hs_count, 32'd0);
`endif

    // Start pulsed mid-run must be ignored
    begin_expect();
    push_word(32'h0000_0005);
    push_word(32'h0000_0006);
    push_word(32'h0000_0001);
    end_expect();
    dc = done_count;
    pulse_start(12'h000, 11'd3);
    repeat (5) @(posedge clk);
    pulse_start(12'h100, 11'd2);
    wait_done("ignored");
    repeat (10) @(posedge clk);
    #1;
    check("ignored_queue_empty", exp_q.size(), 32'd0);
    check("ignored_done_once", done_count, dc + 1);
    check("ignored_final_addr", {20'd0, debug_addr}, 32'h00C);
    check("ignored_busy_after", {31'd0, busy}, 32'd0);

    // Reset after the fifth byte handshake
    begin_expect();
    push_word(32'h0000_0005);
    push_word(32'h0000_0006);
    push_word(32'h0000_0001);
    end_expect();
    pulse_start(12'h000, 11'd3);
    begin
      bit reached = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk);
        if (hs_count == 5) begin
          reached = 1'b1;
          break;
        end
      end
      check("midrst_reached_5", {31'd0, reached}, 32'd1);
    end
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_addr", {20'd0, debug_addr}, 32'd0);
    exp_q.delete();
    rst = 1'b1;
    begin_expect();
    push_word(32'h0000_0005);
    end_expect();
    pulse_start(12'h000, 11'd1);
    wait_done("post_rst");
    check("post_rst_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_dump_streamer.md
Name: bram_dump_streamer

Overview:
Hardware reader for the data BRAM. It is the counterpart of the bench-side loader that writes words into BRAM. On a start pulse it walks a word-aligned address range through the BRAM debug read port and serializes each 32-bit word as four little-endian bytes on a valid/ready byte stream. The stream feeds the board UART TX so memory contents can be checked post-run on the Zybo Z7-20.

Parameters:
ADDR_WIDTH, 12, byte address width of the BRAM debug port
DATA_WIDTH, 32, BRAM word width; fixed at 32 (four bytes per word)
CNT_WIDTH, 11, width of word_count; up to 1024 words (full 4 KiB BRAM)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-low reset
start  input  1  one-cycle request to begin a dump; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first byte address; bits [1:0] ignored (forced 00)
word_count  input  CNT_WIDTH  number of 32-bit words to dump
debug_addr  output  ADDR_WIDTH  address to BRAM debug port; always word-aligned
debug_data  input  DATA_WIDTH  BRAM debug read data, combinational from debug_addr
tx_data  output  8  stream byte
tx_valid  output  1  stream byte valid
tx_ready  input  1  downstream accepts byte when tx_valid & tx_ready at posedge
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when the dump completes

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; debug_addr=0; tx_data=0; tx_valid=0; busy=0; done=0; internal counters=0.
- Reset mid-operation aborts immediately. No partial word is resumed. tx_valid drops in the same edge.
- States: IDLE, FETCH, SEND, (CSUM when the optional feature is enabled), FINISH.
- IDLE: on start==1, latch {base_addr[ADDR_WIDTH-1:2],2'b00} into debug_addr, latch word_count into remaining, busy<=1.
  - If word_count==0, go to FINISH. No bytes are emitted.
  - Otherwise go to FETCH.
- FETCH: one cycle. Capture debug_data into shift register, set byte index to 0, load tx_data with word[7:0], assert tx_valid, go to SEND.
  - Capture latency is one cycle after debug_addr changes. Same-cycle capture is not allowed.
- SEND: hold tx_data and tx_valid stable while !tx_ready. On handshake:
  - If byte index < 3: increment index and present the next byte (word[15:8], [23:16], [31:24]) in the next cycle. No bubble between bytes of one word.
  - If byte index == 3: tx_valid<=0, decrement remaining, and advance debug_addr by 4, wrapping modulo 2^ADDR_WIDTH (0xFFC wraps to 0x000). Then:
    - remaining becomes 0: go to FINISH.
    - otherwise: go to FETCH.
  - Throughput: 4 bytes per 5 cycles with tx_ready held high.
- FINISH: done<=1 for exactly one cycle, busy<=0, return to IDLE.
  - A start arriving in the same cycle as the done pulse is ignored.
- start while busy is ignored and does not restart or corrupt the run.
- Output timing: tx_valid never deasserts without a handshake, except on reset. tx_data changes only after a handshake or when leaving IDLE/FETCH.
- The block never writes the BRAM. BRAM contents changing during a dump are sampled at each FETCH.

Optional Feature:
Macro DUMP_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum, modulo 256, accumulates every accepted byte. It is cleared on accepted start.
  - After the last word, state CSUM presents the sum as one extra byte under the same valid/ready rules, then goes to FINISH.
  - word_count==0 emits only the checksum byte 0x00.
- Not defined: the CSUM state and accumulator are absent. The last word's handshake goes directly to FINISH.

Test Plan:
- Basic dump: preload mem[0x0]=0x00000005, mem[0x4]=0x00000006, mem[0x8]=0x00000001; base_addr=0x000, word_count=3, tx_ready=1 -> bytes 05 00 00 00 06 00 00 00 01 00 00 00; done pulses once; busy low afterward. With DUMP_CHECKSUM_EN, a trailing byte 0x0C follows.
- Backpressure: mem[0x10]=0xA1B2C3D4, base_addr=0x012 (aligned to 0x010), word_count=1; tx_ready toggles 0/1 each cycle -> D4 C3 B2 A1, each byte stable across stalled cycles, no duplicates.
- Wrap-around: base_addr=0xFFC, word_count=2, mem[0xFFC]=0x11111111, mem[0x000]=0x22222222 -> eight bytes 11..11 then 22..22; debug_addr sequence 0xFFC, 0x000.
- Zero count and ignored start: word_count=0 -> no tx_valid, done one cycle after start. During a 3-word run, pulse start with different base_addr -> output unchanged from the basic dump.
- Reset mid-stream: assert rst=0 after the 5th byte handshake -> next edge tx_valid=0, busy=0, debug_addr=0. A new start with base_addr=0, word_count=1 then emits 05 00 00 00.
